// File: rtl/run_event_monitor.sv
// Turns detector run flags into one-cycle event pulses, counts events per window, raises a sticky alarm and tracks run lengths.
// Latency: every output is registered, one clk after the sampled inputs; no combinational input-to-output path.
// Backpressure: none; one det sample is consumed every cycle and the outputs are level/pulse status.
//
// Ports:
//   clk, rst            clock (posedge) and synchronous active-high reset
//   det                 detector level, 1 = run of four detected
//   clr                 synchronous clear of window, counters, alarm and run statistics
//   event_pulse         1-cycle pulse per det rising edge
//   evt_cnt [CNT_W]     events in the current window, saturating
//   alarm               sticky, set when evt_cnt reaches THRESH
//   run_len [LEN_W]     length of last completed run, saturating
//   max_run [LEN_W]     largest run_len since rst/clr
// Build option: define RUN_STATS_EN to build the run-length FSM; otherwise run_len/max_run are tied to 0.

module run_event_monitor #(
    parameter int WINDOW = 200,
    parameter int THRESH = 3,
    parameter int CNT_W  = 4,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clr,
    output logic             event_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             alarm,
    output logic [LEN_W-1:0] run_len,
    output logic [LEN_W-1:0] max_run
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic             det_q;
    logic             rise;
    logic [WIN_W-1:0] win_cnt;
    logic             wrap;
    logic [CNT_W-1:0] evt_next;

    assign rise = det & ~det_q;
    assign wrap = (win_cnt == WIN_W'(WINDOW - 1));

    // An event landing on the wrap cycle is the first event of the new window.
    always_comb begin
        evt_next = evt_cnt;
        if (wrap) begin
            evt_next = rise ? CNT_W'(1) : '0;
        end else if (rise && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_next = evt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det_q       <= 1'b0;
            win_cnt     <= '0;
            evt_cnt     <= '0;
            alarm       <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            // det_q tracks det even under clr so a level held through clr is not a new edge.
            det_q <= det;
            if (clr) begin
                win_cnt     <= '0;
                evt_cnt     <= '0;
                alarm       <= 1'b0;
                event_pulse <= 1'b0;
            end else begin
                event_pulse <= rise;
                win_cnt     <= wrap ? '0 : win_cnt + 1'b1;
                evt_cnt     <= evt_next;
                // Alarm asserts in the same cycle as the pulse of the event that hits THRESH.
                if (evt_next == CNT_W'(THRESH)) begin
                    alarm <= 1'b1;
                end
            end
        end
    end

`ifdef RUN_STATS_EN
    typedef enum logic {IDLE, RUN} run_state_t;

    run_state_t       state;
    logic [LEN_W-1:0] len_cnt;
    logic             fall;

    assign fall = ~det & det_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_cnt <= '0;
            run_len <= '0;
            max_run <= '0;
        end else if (clr) begin
            // A run in progress is abandoned; it is only counted after a fresh rise.
            state   <= IDLE;
            len_cnt <= '0;
            run_len <= '0;
            max_run <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= RUN;
                        len_cnt <= LEN_W'(1);
                    end
                end
                RUN: begin
                    if (fall) begin
                        state   <= IDLE;
                        run_len <= len_cnt;
                        if (len_cnt > max_run) begin
                            max_run <= len_cnt;
                        end
                    end else if (len_cnt != {LEN_W{1'b1}}) begin
                        len_cnt <= len_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign run_len = '0;
    assign max_run = '0;
`endif

endmodule

// File: tb/tb_run_event_monitor.sv
// Self-checking bench for run_event_monitor: vector table, directed corner sequences and a randomized run against a reference model.
// Latency: outputs are compared 1 time unit after each rising clock edge.
// Backpressure: not applicable; one input vector is applied per cycle.

module tb_run_event_monitor;

    localparam int WINDOW = 200;
    localparam int THRESH = 3;
    localparam int CNT_W  = 4;
    localparam int LEN_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LEN_MAX = (1 << LEN_W) - 1;
`ifdef RUN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             det = 1'b0;
    logic             clr = 1'b0;
    logic             event_pulse;
    logic [CNT_W-1:0] evt_cnt;
    logic             alarm;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] max_run;

    always #5 clk = ~clk;

    run_event_monitor #(
        .WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(CNT_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .det(det), .clr(clr),
        .event_pulse(event_pulse), .evt_cnt(evt_cnt), .alarm(alarm),
        .run_len(run_len), .max_run(max_run)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: window position, unsaturated event count, run tracking by cycle count.
    int m_pos = 0;
    int m_n   = 0;
    int m_cur = 0;
    int m_rl  = 0;
    int m_mx  = 0;
    bit m_prev  = 1'b0;
    bit m_pulse = 1'b0;
    bit m_alarm = 1'b0;
    bit m_track = 1'b0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_edge();
        bit r;
        r = det && !m_prev;
        if (rst) begin
            m_pos = 0; m_n = 0; m_cur = 0; m_rl = 0; m_mx = 0;
            m_prev = 1'b0; m_pulse = 1'b0; m_alarm = 1'b0; m_track = 1'b0;
        end else begin
            m_prev = det;
            if (clr) begin
                m_pos = 0; m_n = 0; m_cur = 0; m_rl = 0; m_mx = 0;
                m_pulse = 1'b0; m_alarm = 1'b0; m_track = 1'b0;
            end else begin
                m_pulse = r;
                if (m_pos == WINDOW - 1) begin
                    m_n = r ? 1 : 0;
                    m_pos = 0;
                end else begin
                    m_n = m_n + (r ? 1 : 0);
                    m_pos++;
                end
                if (r && sat(m_n, CNT_MAX) == THRESH) m_alarm = 1'b1;
                if (m_track) begin
                    if (det) m_cur++;
                    else begin
                        m_rl = sat(m_cur, LEN_MAX);
                        if (m_rl > m_mx) m_mx = m_rl;
                        m_track = 1'b0;
                    end
                end else if (r) begin
                    m_track = 1'b1;
                    m_cur = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit d);
        rst = r; clr = c; det = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("mdl_pulse", int'(event_pulse), int'(m_pulse));
        chk("mdl_evt_cnt", int'(evt_cnt), sat(m_n, CNT_MAX));
        chk("mdl_alarm", int'(alarm), int'(m_alarm));
        chk("mdl_run_len", int'(run_len), STATS ? m_rl : 0);
        chk("mdl_max_run", int'(max_run), STATS ? m_mx : 0);
    endtask

    // Drives det low until the next edge is the window wrap.
    task automatic go_to_wrap();
        int guard;
        guard = 0;
        while (m_pos != WINDOW - 1 && guard < 2 * WINDOW) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (m_pos != WINDOW - 1) begin
            n_chk++;
            $display("FAIL wrap_timeout: position %0d, wanted %0d", m_pos, WINDOW - 1);
        end
    endtask

    task automatic run_of(input int len, input string nm);
        int pulses;
        pulses = 0;
        for (int i = 0; i < len; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (event_pulse) pulses++;
        end
        step(1'b0, 1'b0, 1'b0);
        if (event_pulse) pulses++;
        chk({nm, "_pulses"}, pulses, 1);
    endtask

    typedef struct {
        bit r;
        bit c;
        bit d;
        bit p;
        int cnt;
        bit al;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 0};   // det_q reset to 0: first det=1 is a rise
        tbl[3]  = '{0, 0, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 1, 0, 0, 0};   // rise during clr discarded
        tbl[6]  = '{0, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 1, 1, 2, 0};
        tbl[12] = '{0, 0, 0, 0, 2, 0};
        tbl[13] = '{0, 0, 1, 1, 3, 1};   // alarm with third pulse
        tbl[14] = '{0, 0, 0, 0, 3, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d_pulse", i), int'(event_pulse), int'(tbl[i].p));
            chk($sformatf("tbl%0d_cnt", i), int'(evt_cnt), tbl[i].cnt);
            chk($sformatf("tbl%0d_alarm", i), int'(alarm), int'(tbl[i].al));
            if (tbl[i].r) begin
                chk($sformatf("tbl%0d_rst_run_len", i), int'(run_len), 0);
                chk($sformatf("tbl%0d_rst_max_run", i), int'(max_run), 0);
            end
        end

        // Run lengths 3, 5, 2.
        run_of(3, "run3");
        chk("run3_len", int'(run_len), STATS ? 3 : 0);
        chk("run3_max", int'(max_run), STATS ? 3 : 0);
        run_of(5, "run5");
        chk("run5_len", int'(run_len), STATS ? 5 : 0);
        chk("run5_max", int'(max_run), STATS ? 5 : 0);
        run_of(2, "run2");
        chk("run2_len", int'(run_len), STATS ? 2 : 0);
        chk("run2_max", int'(max_run), STATS ? 5 : 0);

        // Alarm with third event, sticky across wrap, cleared by clr.
        step(1'b0, 1'b1, 1'b0);
        chk("clr_alarm", int'(alarm), 0);
        chk("clr_max_run", int'(max_run), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("alm_pulse%0d", i), int'(event_pulse), 1);
            chk($sformatf("alm_level%0d", i), int'(alarm), (i == 2) ? 1 : 0);
            step(1'b0, 1'b0, 1'b0);
        end
        go_to_wrap();
        step(1'b0, 1'b0, 1'b0);
        chk("alm_wrap_cnt", int'(evt_cnt), 0);
        chk("alm_wrap_sticky", int'(alarm), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("alm_clr_alarm", int'(alarm), 0);
        chk("alm_clr_max_run", int'(max_run), 0);

        // Count restarts at wrap; a rise on the wrap cycle counts in the new window.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        go_to_wrap();
        chk("wrap_pre_cnt", int'(evt_cnt), 2);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_post_cnt", int'(evt_cnt), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_new_cnt", int'(evt_cnt), 1);
        chk("wrap_new_alarm", int'(alarm), 0);
        go_to_wrap();
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_edge_pulse", int'(event_pulse), 1);
        chk("wrap_edge_cnt", int'(evt_cnt), 1);
        step(1'b0, 1'b0, 1'b0);

        // Saturation of event count and run length.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("sat_cnt", int'(evt_cnt), 15);
        chk("sat_alarm", int'(alarm), 1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_run_len", int'(run_len), STATS ? 255 : 0);
        chk("sat_max_run", int'(max_run), STATS ? 255 : 0);

        // clr and rise together, det held high afterwards.
        step(1'b0, 1'b1, 1'b1);
        chk("clr_rise_pulse", int'(event_pulse), 0);
        chk("clr_rise_cnt", int'(evt_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("clr_hold_pulse%0d", i), int'(event_pulse), 0);
            chk($sformatf("clr_hold_cnt%0d", i), int'(evt_cnt), 0);
        end
        step(1'b0, 1'b0, 0);
        chk("clr_hold_run_len", int'(run_len), 0);

        // rst mid-run loses the run.
        run_of(4, "pre_rst");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_mid_run_len", int'(run_len), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_mid_after_len", int'(run_len), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r, c, d;
            r = ($urandom_range(0, 599) == 0);
            c = ($urandom_range(0, 149) == 0);
            d = ($urandom_range(0, 3) == 0) ? ~det : det;
            step(r, c, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
